seq_hit_monitor: RTL and testbench



---
 rtl/seq_mon_pkg.sv | 25 ++
 rtl/seq_sat_cnt.sv | 30 +++
 rtl/seq_hit_monitor.sv | 128 ++++++++++++
 tb/tb_seq_hit_monitor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seq_mon_pkg.sv
// Shared types and helpers for the sequence-hit window monitor.
package seq_mon_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mon_state_e;

   // Width needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

   // All-ones value of a given width: the gap sentinel and the saturation ceiling.
   function automatic logic [31:0] all_ones(input int width);
      if (width >= 32) return '1;
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear applies before the increment,
// so clear and increment together load a count of one.
module seq_sat_cnt
   import seq_mon_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d, base;

   always_comb begin
      base  = clr_i ? '0 : cnt_q;
      cnt_d = base;
      if (inc_i && !(&base)) cnt_d = base + W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_hit_monitor.sv
// Counts detector hits over fixed windows, tracks the minimum hit spacing and
// publishes a per-window report through a single valid/ready holding register.
module seq_hit_monitor
   import seq_mon_pkg::*;
#(
   parameter  int WIN_LEN = 64,
   parameter  int CNT_W   = 8,
   parameter  int THRESH  = 4,
   localparam int GAP_W   = clog2(WIN_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             hit,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [CNT_W-1:0] rpt_count,
   output logic             rpt_alarm,
   output logic [GAP_W-1:0] rpt_min_gap,
   output logic             rpt_lost
);

   localparam logic [GAP_W-1:0] GAP_ONES = GAP_W'(all_ones(GAP_W));
   localparam logic [GAP_W-1:0] WIN_LAST = GAP_W'(WIN_LEN - 1);

   mon_state_e       state_q, state_d;
   logic [GAP_W-1:0] win_q, win_d;
   logic             have_hit_q, have_hit_d;
   logic [GAP_W-1:0] min_gap_q, min_gap_d;
   logic             rpt_valid_q, rpt_valid_d;
   logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
   logic             rpt_alarm_q, rpt_alarm_d;
   logic [GAP_W-1:0] rpt_min_gap_q, rpt_min_gap_d;
   logic             rpt_lost_q, rpt_lost_d;

   logic             run_act, win_close, hit_v;
   logic [CNT_W-1:0] hit_cnt, close_cnt;
   logic [GAP_W-1:0] gap, min_cand;

   assign run_act   = (state_q == RUN) && en;
   assign win_close = run_act && (win_q == WIN_LAST);
   assign hit_v     = run_act && hit;

   seq_sat_cnt #(.W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (!run_act || win_close),
      .inc_i (hit_v && !win_close),
      .cnt_o (hit_cnt)
   );

   // Restarts at one on every hit, so at the next hit it equals the hit distance.
   seq_sat_cnt #(.W(GAP_W)) u_gap (
      .clk   (clk),
      .rst   (rst),
      .clr_i (!run_act || win_close || hit_v),
      .inc_i (run_act && !win_close),
      .cnt_o (gap)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en)  state_d = RUN;
         RUN:     if (!en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      win_d = '0;
      if (run_act && !win_close) win_d = win_q + GAP_W'(1);
      have_hit_d = run_act && !win_close && (have_hit_q || hit_v);

      min_cand = min_gap_q;
      if (hit_v && have_hit_q && (gap < min_gap_q)) min_cand = gap;
      min_gap_d = (run_act && !win_close) ? min_cand : GAP_ONES;

      close_cnt = hit_cnt;
      if (hit_v && !(&hit_cnt)) close_cnt = hit_cnt + CNT_W'(1);

      rpt_valid_d   = rpt_valid_q;
      rpt_count_d   = rpt_count_q;
      rpt_alarm_d   = rpt_alarm_q;
      rpt_min_gap_d = rpt_min_gap_q;
      rpt_lost_d    = rpt_lost_q;
      if (rpt_valid_q && rpt_ready) rpt_valid_d = 1'b0;
      // A report accepted in the closing cycle frees the slot, so no loss.
      if (win_close) begin
         rpt_valid_d   = 1'b1;
         rpt_count_d   = close_cnt;
         rpt_alarm_d   = int'(close_cnt) >= THRESH;
         rpt_min_gap_d = min_cand;
         rpt_lost_d    = rpt_valid_q && !rpt_ready;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         win_q         <= '0;
         have_hit_q    <= 1'b0;
         min_gap_q     <= GAP_ONES;
         rpt_valid_q   <= 1'b0;
         rpt_count_q   <= '0;
         rpt_alarm_q   <= 1'b0;
         rpt_min_gap_q <= '0;
         rpt_lost_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         win_q         <= win_d;
         have_hit_q    <= have_hit_d;
         min_gap_q     <= min_gap_d;
         rpt_valid_q   <= rpt_valid_d;
         rpt_count_q   <= rpt_count_d;
         rpt_alarm_q   <= rpt_alarm_d;
         rpt_min_gap_q <= rpt_min_gap_d;
         rpt_lost_q    <= rpt_lost_d;
      end
   end

   assign rpt_valid   = rpt_valid_q;
   assign rpt_count   = rpt_count_q;
   assign rpt_alarm   = rpt_alarm_q;
   assign rpt_min_gap = rpt_min_gap_q;
   assign rpt_lost    = rpt_lost_q;

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Directed and random bench for seq_hit_monitor against a window-level reference model.
module tb_seq_hit_monitor;

   localparam int WIN_LEN  = 16;
   localparam int CNT_W    = 4;
   localparam int THRESH   = 4;
   localparam int GAP_W    = 5;
   localparam int CNT_MAX  = 15;
   localparam int GAP_ONES = 31;

   logic             clk = 1'b0;
   logic             rst, en, hit, rpt_ready;
   logic             rpt_valid, rpt_alarm, rpt_lost;
   logic [CNT_W-1:0] rpt_count;
   logic [GAP_W-1:0] rpt_min_gap;

   always #5 clk = ~clk;

   seq_hit_monitor #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .hit         (hit),
      .rpt_valid   (rpt_valid),
      .rpt_ready   (rpt_ready),
      .rpt_count   (rpt_count),
      .rpt_alarm   (rpt_alarm),
      .rpt_min_gap (rpt_min_gap),
      .rpt_lost    (rpt_lost)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: window position plus the list of hit positions in the window.
   bit m_run = 0;
   int m_pos = 0;
   int m_hits[$];
   bit m_valid = 0;
   bit m_closed = 0;
   int m_count = 0, m_alarm = 0, m_gap = 0, m_lost = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rpt(input string tag, input int v, input int c, input int a,
                          input int g, input int l);
      chk({tag, "_valid"}, 32'(rpt_valid), v);
      chk({tag, "_count"}, 32'(rpt_count), c);
      chk({tag, "_alarm"}, 32'(rpt_alarm), a);
      chk({tag, "_gap"},   32'(rpt_min_gap), g);
      chk({tag, "_lost"},  32'(rpt_lost), l);
   endtask

   task automatic model_edge(input bit rs, input bit e, input bit h, input bit r);
      bit accept;
      int n, g;
      m_closed = 0;
      if (!rs) begin
         m_run = 0; m_pos = 0; m_hits.delete();
         m_valid = 0; m_count = 0; m_alarm = 0; m_gap = 0; m_lost = 0;
      end else begin
         accept = m_valid && r;
         if (!m_run) begin
            if (e) begin m_run = 1; m_pos = 0; m_hits.delete(); end
         end else if (!e) begin
            m_run = 0; m_hits.delete();
         end else begin
            if (h) m_hits.push_back(m_pos);
            if (m_pos == WIN_LEN - 1) begin
               n = m_hits.size();
               g = GAP_ONES;
               for (int i = 1; i < n; i++)
                  if (m_hits[i] - m_hits[i-1] < g) g = m_hits[i] - m_hits[i-1];
               m_count = (n > CNT_MAX) ? CNT_MAX : n;
               m_alarm = (m_count >= THRESH) ? 1 : 0;
               m_gap   = g;
               m_lost  = (m_valid && !r) ? 1 : 0;
               m_valid = 1;
               m_closed = 1;
               m_hits.delete();
               m_pos = 0;
            end else begin
               m_pos++;
            end
         end
         if (accept && !m_closed) m_valid = 0;
      end
   endtask

   task automatic step(input bit rs, input bit e, input bit h, input bit r);
      rst = rs; en = e; hit = h; rpt_ready = r;
      @(posedge clk);
      model_edge(rs, e, h, r);
      #1;
      chk("valid", 32'(rpt_valid), 32'(m_valid));
      if (m_valid) begin
         chk("count", 32'(rpt_count), m_count);
         chk("alarm", 32'(rpt_alarm), m_alarm);
         chk("min_gap", 32'(rpt_min_gap), m_gap);
         chk("lost", 32'(rpt_lost), m_lost);
      end
      if (m_closed)
         $display("report: count=%0d alarm=%0d min_gap=%0d lost=%0d",
                  rpt_count, rpt_alarm, rpt_min_gap, rpt_lost);
   endtask

   task automatic window(input logic [15:0] pat, input bit r_first, input bit r_body,
                         input bit r_close);
      bit r;
      for (int i = 0; i < WIN_LEN; i++) begin
         r = (i == 0) ? r_first : ((i == WIN_LEN - 1) ? r_close : r_body);
         step(1'b1, 1'b1, pat[i], r);
      end
   endtask

   initial begin
      // Reset held with en and hit active.
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk_rpt("reset", 0, 0, 0, 0, 0);

      // E0 plus 15 window cycles: nothing reported yet; the 17th edge closes.
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("latency_valid", 32'(rpt_valid), 0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk_rpt("saturate", 1, 15, 1, 1, 0);

      window(16'h0828, 1, 1, 1);
      chk_rpt("hits_3_5_11", 1, 3, 0, 2, 0);
      window(16'hAAAA, 1, 1, 1);
      chk_rpt("every_2nd", 1, 8, 1, 2, 0);
      window(16'h0000, 1, 1, 1);
      chk_rpt("no_hits", 1, 0, 0, GAP_ONES, 0);
      window(16'h8000, 1, 1, 1);
      chk_rpt("hit_at_close", 1, 1, 0, GAP_ONES, 0);

      // Consumer stalled across two closes, then ready exactly at the third close.
      window(16'h0011, 1, 0, 0);
      chk_rpt("stall_first", 1, 2, 0, 4, 0);
      window(16'h0155, 0, 0, 0);
      chk_rpt("overwrite", 1, 5, 1, 2, 1);
      window(16'h0101, 0, 0, 1);
      chk_rpt("accept_at_close", 1, 2, 0, 8, 0);

      // Abort at window cycle 7, idle, then a fresh window.
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, (i == 2 || i == 5), 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("abort_no_report", 32'(rpt_valid), 0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      window(16'h0300, 1, 1, 1);
      chk_rpt("after_abort", 1, 2, 0, 1, 0);

      // Reset pulse at window cycle 9 with a report still pending.
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, (i % 3 == 0), 1'b0);
      chk("pending_before_rst", 32'(rpt_valid), 1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk_rpt("mid_rst", 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

      // Random traffic, including gap-1 hits, enable drops, stalls and resets.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 59) != 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
